// File: rtl/cla_multiword_seq_pkg.sv
// rtl/cla_multiword_seq_pkg.sv - shared state encoding and index-width helper for the word-serial CLA adder
package cla_multiword_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A single-word build still needs a one-bit index register.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// rtl/cla_slice.sv - combinational NBITS-wide carry-lookahead adder slice
module cla_slice #(
    parameter int NBITS = 4
) (
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic             ci,
    output logic [NBITS-1:0] s,
    output logic             co
);

    logic [NBITS-1:0] g;
    logic [NBITS-1:0] p;
    logic [NBITS:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flattened sum-of-products over all lower generates, not a ripple chain.
    always_comb begin
        logic term;
        logic prop;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < NBITS; i++) begin
            term = g[i];
            prop = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = term | (prop & ci);
        end
    end

    assign s  = p ^ c[NBITS-1:0];
    assign co = c[NBITS];

endmodule

// File: rtl/cla_multiword_seq.sv
// rtl/cla_multiword_seq.sv - wide adder time-multiplexing one CLA slice, LS word first
// Optional subtract mode (A - B) is enabled by defining CLA_SEQ_SUBTRACT_EN.
module cla_multiword_seq
    import cla_multiword_seq_pkg::*;
#(
    parameter int NBITS = 4,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NBITS*WORDS-1:0] a,
    input  logic [NBITS*WORDS-1:0] b,
    input  logic                   cin,
`ifdef CLA_SEQ_SUBTRACT_EN
    input  logic                   sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NBITS*WORDS-1:0] sum,
    output logic                   cout,
    output logic                   busy
);

    localparam int W  = NBITS * WORDS;
    localparam int IW = idx_width(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            cout_q, cout_d;
`ifdef CLA_SEQ_SUBTRACT_EN
    logic            sub_q, sub_d;
`endif

    int              word_lsb;
    logic [NBITS-1:0] slice_a, slice_b, slice_s;
    logic            slice_co;

    always_comb begin
        word_lsb = int'(idx_q) * NBITS;
        slice_a  = a_q[word_lsb +: NBITS];
        slice_b  = b_q[word_lsb +: NBITS];
`ifdef CLA_SEQ_SUBTRACT_EN
        if (sub_q) begin
            slice_b = ~slice_b;
        end
`endif
    end

    cla_slice #(.NBITS(NBITS)) u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef CLA_SEQ_SUBTRACT_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    state_d = ST_ADD;
`ifdef CLA_SEQ_SUBTRACT_EN
                    // Two's-complement subtract: the +1 enters as the initial carry.
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
`else
                    carry_d = cin;
`endif
                end
            end
            ST_ADD: begin
                sum_d[word_lsb +: NBITS] = slice_s;
                carry_d                  = slice_co;
                if (idx_q == LAST_IDX) begin
                    cout_d  = slice_co;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef CLA_SEQ_SUBTRACT_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef CLA_SEQ_SUBTRACT_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_ADD);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// tb/tb_cla_multiword_seq.sv - randomized self-checking bench for cla_multiword_seq (NBITS=4, WORDS=4)
module tb_cla_multiword_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
`ifdef CLA_SEQ_SUBTRACT_EN
    logic        sub;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cla_multiword_seq #(.NBITS(4), .WORDS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUBTRACT_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    // Reference: plain 17-bit arithmetic on the whole operands.
    function automatic logic [16:0] ref_model(input logic [15:0] x, input logic [15:0] y,
                                              input logic ci, input logic sb);
        if (sb) return {1'b0, x} + {1'b0, ~y} + 17'd1;
        return {1'b0, x} + {1'b0, y} + {16'd0, ci};
    endfunction

    task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic ci,
                         input logic sb, output logic [15:0] s, output logic co,
                         output int lat, output int bcnt, output bit ok);
        int n;
        ok   = 1'b1;
        lat  = 0;
        bcnt = 0;
        n    = 0;
        @(negedge clk);
        a = x; b = y; cin = ci; in_valid = 1'b1;
`ifdef CLA_SEQ_SUBTRACT_EN
        sub = sb;
`else
        if (sb) ok = 1'b0;
`endif
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) ok = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        while (!out_valid && lat < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (!out_valid) ok = 1'b0;
        s = sum;
        co = cout;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef CLA_SEQ_SUBTRACT_EN
        sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (sum !== 16'h0000 || cout !== 1'b0) begin errors++; $display("FAIL reset_sum: got %h/%b expected 0000/0", sum, cout); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL reset_release: got in_ready %b out_valid %b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_directed();
        logic [15:0] s; logic co; int lat, bc; bit ok;
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, s, co, lat, bc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL dir1_handshake: got timeout expected completion"); end
        checks++; if (s !== 16'h0100 || co !== 1'b0) begin errors++; $display("FAIL dir1_result: got %h/%b expected 0100/0", s, co); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL dir1_latency: got %0d expected 4", lat); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL dir1_busy_cycles: got %0d expected 4", bc); end
        do_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, s, co, lat, bc, ok);
        checks++; if (!ok || s !== 16'h0000 || co !== 1'b1) begin errors++; $display("FAIL dir2_ripple: got %h/%b ok %b expected 0000/1", s, co, ok); end
        do_op(16'h8000, 16'h8000, 1'b0, 1'b0, s, co, lat, bc, ok);
        checks++; if (!ok || s !== 16'h0000 || co !== 1'b1) begin errors++; $display("FAIL dir2_msb: got %h/%b ok %b expected 0000/1", s, co, ok); end
    endtask

    task automatic test_random();
        logic [15:0] x, y, s; logic ci, sb, co; int lat, bc; bit ok; logic [16:0] exp;
        for (int i = 0; i < 24; i++) begin
            x = 16'($urandom); y = 16'($urandom); ci = 1'($urandom);
`ifdef CLA_SEQ_SUBTRACT_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            exp = ref_model(x, y, ci, sb);
            do_op(x, y, ci, sb, s, co, lat, bc, ok);
            checks++;
            if (!ok || s !== exp[15:0] || co !== exp[16] || lat !== 4) begin
                errors++;
                $display("FAIL random_%0d: a %h b %h cin %b sub %b got %h/%b lat %0d expected %h/%b lat 4",
                         i, x, y, ci, sb, s, co, lat, exp[15:0], exp[16]);
            end
        end
    endtask

    task automatic test_hold();
        logic [16:0] exp; int n;
        exp = ref_model(16'h1357, 16'h2468, 1'b0, 1'b0);
        n = 0;
        @(negedge clk);
        a = 16'h1357; b = 16'h2468; cin = 1'b0; in_valid = 1'b1;
`ifdef CLA_SEQ_SUBTRACT_EN
        sub = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        checks++; if (!out_valid) begin errors++; $display("FAIL hold_reach_done: got out_valid 0 expected 1"); end
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom); cin = 1'($urandom);
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== exp[15:0] || cout !== exp[16]) begin
                errors++;
                $display("FAIL hold_cycle_%0d: got valid %b ready %b sum %h cout %b expected 1/0/%h/%b",
                         i, out_valid, in_ready, sum, cout, exp[15:0], exp[16]);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== exp[15:0]) begin
            errors++;
            $display("FAIL hold_release: got ready %b valid %b sum %h expected 1/0/%h", in_ready, out_valid, sum, exp[15:0]);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] s; logic co; int lat, bc; bit ok;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== 16'h0000 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got valid %b busy %b sum %h ready %b expected 0/0/0000/1", out_valid, busy, sum, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        do_op(16'h1234, 16'h4321, 1'b1, 1'b0, s, co, lat, bc, ok);
        checks++; if (!ok || s !== 16'h5556 || co !== 1'b0) begin errors++; $display("FAIL reset_mid_next: got %h/%b ok %b expected 5556/0", s, co, ok); end
    endtask

    task automatic test_back_to_back();
        int n;
        n = 0;
        @(negedge clk);
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b0; in_valid = 1'b1;
`ifdef CLA_SEQ_SUBTRACT_EN
        sub = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        checks++; if (!out_valid || sum !== 16'h1000 || cout !== 1'b0) begin errors++; $display("FAIL b2b_first: got valid %b %h/%b expected 1 1000/0", out_valid, sum, cout); end
        a = 16'hABCD; b = 16'h5433; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b expected 1", busy); end
        n = 0;
        while (!out_valid && n < 40) begin @(negedge clk); n++; end
        checks++; if (!out_valid || sum !== 16'h0000 || cout !== 1'b1) begin errors++; $display("FAIL b2b_second: got valid %b %h/%b expected 1 0000/1", out_valid, sum, cout); end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

`ifdef CLA_SEQ_SUBTRACT_EN
    task automatic test_subtract();
        logic [15:0] s; logic co; int lat, bc; bit ok;
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, s, co, lat, bc, ok);
        checks++; if (!ok || s !== 16'hFFFE || co !== 1'b0) begin errors++; $display("FAIL sub_borrow: got %h/%b ok %b expected FFFE/0", s, co, ok); end
        do_op(16'h0007, 16'h0005, 1'b0, 1'b1, s, co, lat, bc, ok);
        checks++; if (!ok || s !== 16'h0002 || co !== 1'b1) begin errors++; $display("FAIL sub_noborrow: got %h/%b ok %b expected 0002/1", s, co, ok); end
    endtask
`endif

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_reset_mid();
        test_back_to_back();
`ifdef CLA_SEQ_SUBTRACT_EN
        test_subtract();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_multiword_seq.md
Name: cla_multiword_seq

Overview:
- Sequencer that performs a wide addition (NBITS*WORDS bits) by time-multiplexing one NBITS-wide carry-lookahead slice over WORDS cycles, least-significant word first.
- The carry is registered between words.
- Valid/ready handshake on both input and output.
- Sits between an operand source and a result consumer wherever a wide adder is too costly in area but several cycles of latency are acceptable.

Parameters:
- NBITS, 4, width of the shared CLA slice (bits per word).
- WORDS, 4, number of words per operand; total operand width W = NBITS*WORDS; WORDS >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  W  operand A.
- b  in  W  operand B.
- cin  in  1  carry into the least-significant word.
- out_valid  out  1  result available (high only in DONE).
- out_ready  in  1  consumer accepts the result.
- sum  out  W  result.
- cout  out  1  carry out of the most-significant word.
- busy  out  1  high in ADD.

Behaviour:
- Reset: clk and rst are the only clock and reset. Reset is asynchronous and active-high. While rst is high or on release:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0, sum = 0, cout = 0, word index = 0, carry register = 0.
  - Operand registers are cleared to 0.
- States: IDLE, ADD, DONE, binary-encoded.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: capture a, b and cin (carry_reg <= cin), set idx <= 0, go to ADD.
  - a, b and cin are sampled only at acceptance; later input changes have no effect.
- ADD (busy = 1, in_ready = 0), one word per cycle:
  - slice inputs = A[idx], B[idx], carry_reg.
  - sum[idx] <= slice sum; carry_reg <= slice carry-out; idx <= idx + 1.
  - When idx == WORDS-1: cout <= slice carry-out, go to DONE, idx <= 0.
  - WORDS == 1: exactly one ADD cycle.
- Latency:
  - Acceptance edge k; ADD edges k+1 .. k+WORDS.
  - out_valid rises after edge k+WORDS (WORDS cycles after acceptance).
  - Throughput is one operation per WORDS+2 cycles minimum.
- DONE:
  - out_valid = 1; sum and cout are held stable.
  - On an edge with out_ready = 1: go to IDLE.
  - out_valid falls and in_ready rises after the same edge; no same-cycle accept of new operands.
  - sum and cout keep their last value in IDLE until the next word writes.
- in_valid while in ADD or DONE: ignored and not queued; the requester must hold in_valid until in_ready is high.
- Arithmetic: unsigned modulo 2^W, with the carry in cout. Example: all-ones + 0 with cin = 1 gives sum = 0, cout = 1, with the carry propagating through every word.
- Reset mid-operation (ADD or DONE): the operation is aborted, its result is discarded, and all outputs return to reset values.
- out_ready while not in DONE: no effect.

Optional Feature:
- Macro: CLA_SEQ_SUBTRACT_EN.
- Defined:
  - Adds input port sub (1 bit), captured at acceptance.
  - sub = 1: computes A - B as A + ~B + 1. Each B word is inverted at the slice input, the initial carry_reg is 1, and cin is ignored.
  - cout = 1 means no borrow (A >= B).
  - sub = 0: behaviour identical to the base block.
- Undefined: no sub port; addition only.

Decomposition:
- Shared include cla_seq_defs.vh holds:
  - state encodings ST_IDLE = 2'd0, ST_ADD = 2'd1, ST_DONE = 2'd2;
  - an index-width function/localparam (clog2 of WORDS, minimum 1).
- Sub-module cla_slice:
  - purely combinational NBITS-wide carry-lookahead adder (a, b, ci -> s, co);
  - generate/propagate per bit with lookahead carries;
  - instantiated once.
- Controller FSM, index counter, operand and result registers live in cla_multiword_seq.

Test Plan:
All cases use NBITS = 4, WORDS = 4 (W = 16).
1. a = 16'h00FF, b = 16'h0001, cin = 0 -> sum 16'h0100, cout 0; out_valid exactly 4 cycles after acceptance; busy high for exactly 4 cycles.
2. a = 16'hFFFF, b = 16'h0000, cin = 1 -> sum 16'h0000, cout 1 (full carry ripple across words); a = 16'h8000, b = 16'h8000, cin = 0 -> sum 0, cout 1.
3. Hold out_ready = 0 for 6 cycles in DONE while toggling a, b and in_valid -> out_valid, sum and cout stay constant, in_ready stays 0, no new acceptance; out_ready = 1 -> in_ready = 1 the next cycle.
4. Assert rst after 2 ADD cycles -> out_valid = 0, busy = 0, sum = 0, in_ready = 1 immediately; then a = 16'h1234, b = 16'h4321, cin = 1 -> sum 16'h5556, cout 0.
5. in_valid held high across two operations (16'h0F0F + 16'h00F1, then 16'hABCD + 16'h5433) -> results 16'h1000/cout 0, then 16'h0000/cout 1; second acceptance on the first cycle in_ready is high after the out handshake.
6. CLA_SEQ_SUBTRACT_EN: sub = 1, a = 16'h0005, b = 16'h0007 -> sum 16'hFFFE, cout 0; a = 16'h0007, b = 16'h0005, cin = 0 -> sum 16'h0002, cout 1.
